// File: rtl/shift_arbiter_seq_if.sv
// Request/response bundle between the two requesters, the consumer and
// the shared shift arbiter.
interface shift_arbiter_seq_if #(
    parameter int DATA_W = 4,
    parameter int AMT_W  = 3
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_data;
    logic [AMT_W-1:0]  req0_amt;
    logic              req0_dir;
    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_data;
    logic [AMT_W-1:0]  req1_amt;
    logic              req1_dir;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_id;
    logic              busy;

    modport master (
        output req0_valid, req0_data, req0_amt, req0_dir,
        output req1_valid, req1_data, req1_amt, req1_dir,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_data, rsp_id, busy
    );

    modport slave (
        input  req0_valid, req0_data, req0_amt, req0_dir,
        input  req1_valid, req1_data, req1_amt, req1_dir,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_data, rsp_id, busy
    );
endinterface

// File: rtl/shift_arbiter_seq.sv
// Round-robin arbiter sharing a 0..2-bit shift stage between two requesters;
// larger shifts are built from repeated passes.
module shift_arbiter_seq #(
    parameter int DATA_W = 4,
    parameter int AMT_W  = 3
) (
    input logic               clk,
    input logic               rst_n,
    shift_arbiter_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] acc, acc_nxt;
    logic [AMT_W-1:0]  rem, rem_nxt;
    logic              dir, dir_nxt;
    logic              id, id_nxt;
    logic              last_grant, last_grant_nxt;

    logic              any_valid;
    logic              grant;
    logic              accept;
    logic [DATA_W-1:0] sel_data;
    logic [AMT_W-1:0]  sel_amt;
    logic              sel_dir;
    logic [1:0]        step;
    logic [DATA_W-1:0] staged;

    function automatic logic [DATA_W-1:0] stage(
        input logic [DATA_W-1:0] v,
        input logic [1:0]        s,
        input logic              r
    );
        return r ? (v >> s) : (v << s);
    endfunction

    assign any_valid = bus.req0_valid | bus.req1_valid;
    // Contention goes to the requester that was not served last.
    assign grant = (bus.req0_valid & bus.req1_valid) ? ~last_grant
                                                     : bus.req1_valid;
    assign accept = (state == IDLE) & any_valid;

    assign bus.req0_ready = accept & ~grant;
    assign bus.req1_ready = accept & grant;

    assign sel_data = grant ? bus.req1_data : bus.req0_data;
    assign sel_amt  = grant ? bus.req1_amt  : bus.req0_amt;
    assign sel_dir  = grant ? bus.req1_dir  : bus.req0_dir;

    assign step   = (rem >= AMT_W'(2)) ? 2'd2 : {1'b0, rem[0]};
    assign staged = stage(acc, step, dir);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= '0;
            rem        <= '0;
            dir        <= 1'b0;
            id         <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            acc        <= acc_nxt;
            rem        <= rem_nxt;
            dir        <= dir_nxt;
            id         <= id_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        acc_nxt        = acc;
        rem_nxt        = rem;
        dir_nxt        = dir;
        id_nxt         = id;
        last_grant_nxt = last_grant;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    acc_nxt        = sel_data;
                    rem_nxt        = sel_amt;
                    dir_nxt        = sel_dir;
                    id_nxt         = grant;
                    last_grant_nxt = grant;
                    state_nxt      = (sel_amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                acc_nxt = staged;
                rem_nxt = rem - AMT_W'(step);
                if (rem == AMT_W'(step)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.rsp_valid = (state == DONE);
    assign bus.rsp_data  = (state == DONE) ? acc : '0;
    assign bus.rsp_id    = id;
    assign bus.busy      = (state != IDLE);

    step_legal: assert property (
        @(posedge clk) disable iff (!rst_n) step != 2'b11
    );
endmodule

// File: tb/tb_shift_arbiter_seq.sv
// Bench for shift_arbiter_seq: directed ops checked every cycle against an
// abstract model of arbitration, latency and shift result.
module tb_shift_arbiter_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shift_arbiter_seq_if #(.DATA_W(4), .AMT_W(3)) bus ();

    shift_arbiter_seq #(.DATA_W(4), .AMT_W(3)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    bit       m_busy = 0;
    int       m_wait = 0;
    bit       m_lg = 1;
    bit [3:0] m_res = 0;
    bit       m_id = 0;

    // observations for literal checks
    int       obs_cnt = 0;
    bit       obs_on = 0;
    int       last_lat = 0;
    bit [3:0] last_data = 0;
    bit       last_id = 0;
    int       n_rsp = 0;
    int       gq[$];
    int       rq[$];

    task automatic chk(input string n, input logic [31:0] got,
                       input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", n, got, want);
        end
    endtask

    function automatic bit [3:0] exp_res(input bit [3:0] d, input bit [2:0] a,
                                         input bit r);
        bit [7:0] w;
        w = r ? (8'(d) >> a) : (8'(d) << a);
        return w[3:0];
    endfunction

    function automatic int exp_lat(input bit [2:0] a);
        return (a == 0) ? 1 : 1 + (int'(a) + 1) / 2;
    endfunction

    always @(negedge clk) begin
        bit e0, e1, ev;
        if (!rst_n) begin
            m_busy = 0;
            m_wait = 0;
            m_lg   = 1;
            obs_on = 0;
            chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
            chk("rst_rsp_data", 32'(bus.rsp_data), 0);
            chk("rst_rsp_id", 32'(bus.rsp_id), 0);
            chk("rst_busy", 32'(bus.busy), 0);
        end else begin
            if (m_busy && m_wait > 0) m_wait--;
            if (obs_on) obs_cnt++;
            e0 = !m_busy && bus.req0_valid && (!bus.req1_valid || m_lg);
            e1 = !m_busy && bus.req1_valid && (!bus.req0_valid || !m_lg);
            ev = m_busy && (m_wait == 0);
            chk("ready0", 32'(bus.req0_ready), 32'(e0));
            chk("ready1", 32'(bus.req1_ready), 32'(e1));
            chk("ready_excl", 32'(bus.req0_ready & bus.req1_ready), 0);
            chk("busy", 32'(bus.busy), 32'(m_busy));
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(ev));
            chk("stage_step", 32'(dut.step == 2'b11), 0);
            if (obs_on && bus.rsp_valid) begin
                last_lat = obs_cnt;
                obs_on = 0;
            end
            if (ev) begin
                chk("rsp_data", 32'(bus.rsp_data), 32'(m_res));
                chk("rsp_id", 32'(bus.rsp_id), 32'(m_id));
                last_data = bus.rsp_data;
                last_id = bus.rsp_id;
                if (bus.rsp_ready) begin
                    m_busy = 0;
                    n_rsp++;
                    rq.push_back(int'(m_id));
                end
            end else if (e0 || e1) begin
                m_id = e1;
                m_lg = e1;
                m_res = e1 ? exp_res(bus.req1_data, bus.req1_amt, bus.req1_dir)
                           : exp_res(bus.req0_data, bus.req0_amt, bus.req0_dir);
                m_wait = e1 ? exp_lat(bus.req1_amt) : exp_lat(bus.req0_amt);
                m_busy = 1;
                gq.push_back(int'(e1));
                obs_cnt = 0;
                obs_on = 1;
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int id, input bit v, input bit [3:0] d,
                         input bit [2:0] a, input bit r);
        if (id == 0) begin
            bus.req0_valid = v;
            bus.req0_data = d;
            bus.req0_amt = a;
            bus.req0_dir = r;
        end else begin
            bus.req1_valid = v;
            bus.req1_data = d;
            bus.req1_amt = a;
            bus.req1_dir = r;
        end
    endtask

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input int id, input bit [3:0] d, input bit [2:0] a,
                         input bit r, output int t);
        bit rdy;
        t = 0;
        drive(id, 1, d, a, r);
        do begin
            @(negedge clk);
            t++;
            rdy = (id == 0) ? bus.req0_ready : bus.req1_ready;
        end while (!rdy && t < 100);
        if (!rdy) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        drive(id, 0, d, a, r);
    endtask

    task automatic wait_idle();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((bus.busy || bus.rsp_valid) && t < 100);
        if (t >= 100) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        int t, t2;
        bit [2:0] amts[3] = '{3'd4, 3'd5, 3'd7};
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        bus.rsp_ready = 1;
        repeat (2) @(negedge clk);
        sync();
        rst_n = 1;

        // 1: single op, first IDLE cycle accept
        issue(0, 4'b1011, 3'd3, 0, t);
        chk("t1_wait", 32'(t), 1);
        wait_idle();
        chk("t1_data", 32'(last_data), 32'b1000);
        chk("t1_id", 32'(last_id), 0);
        chk("t1_lat", 32'(last_lat), 3);

        // 2: right shifts from requester 1
        sync();
        issue(1, 4'b1011, 3'd1, 1, t);
        wait_idle();
        chk("t2_data", 32'(last_data), 32'b0101);
        chk("t2_id", 32'(last_id), 1);
        chk("t2_lat", 32'(last_lat), 2);
        sync();
        issue(1, 4'b1011, 3'd0, 1, t);
        wait_idle();
        chk("t2_data0", 32'(last_data), 32'b1011);
        chk("t2_lat0", 32'(last_lat), 1);

        // 3: shifts past the width flush to zero
        for (int i = 0; i < 3; i++) begin
            for (int r = 0; r < 2; r++) begin
                sync();
                issue(1, 4'b1111, amts[i], r[0], t);
                wait_idle();
                chk("t3_data", 32'(last_data), 0);
                if (amts[i] == 3'd7) chk("t3_lat7", 32'(last_lat), 5);
            end
        end

        // 4: continuous contention alternates
        gq.delete();
        rq.delete();
        sync();
        fork
            begin
                issue(0, 4'b0011, 3'd2, 0, t);
                issue(0, 4'b0101, 3'd2, 1, t);
            end
            begin
                issue(1, 4'b1100, 3'd2, 1, t2);
                issue(1, 4'b0110, 3'd2, 0, t2);
            end
        join
        wait_idle();
        chk("t4_ngrant", 32'(gq.size()), 4);
        chk("t4_nrsp", 32'(rq.size()), 4);
        if (gq.size() == 4 && rq.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t4_grant", 32'(gq[i]), 32'(i % 2));
                chk("t4_rsp_id", 32'(rq[i]), 32'(i % 2));
            end
        end

        // 5: consumer back-pressure holds the response
        bus.rsp_ready = 0;
        sync();
        issue(0, 4'b0110, 3'd1, 0, t);
        drive(1, 1, 4'b1001, 3'd1, 1);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.rsp_valid && t < 50);
        chk("t5_valid_seen", 32'(bus.rsp_valid), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_hold_valid", 32'(bus.rsp_valid), 1);
            chk("t5_hold_data", 32'(bus.rsp_data), 32'b1100);
            chk("t5_hold_id", 32'(bus.rsp_id), 0);
            chk("t5_hold_busy", 32'(bus.busy), 1);
            chk("t5_hold_rdy", 32'({bus.req0_ready, bus.req1_ready}), 0);
        end
        sync();
        bus.rsp_ready = 1;
        sync();
        chk("t5_idle_busy", 32'(bus.busy), 0);
        chk("t5_idle_rdy1", 32'(bus.req1_ready), 1);
        sync();
        drive(1, 0, 4'b1001, 3'd1, 1);
        wait_idle();
        chk("t5_req1_data", 32'(last_data), 32'b0100);

        // 6: reset mid-shift, then req0 must win
        sync();
        issue(0, 4'b0001, 3'd6, 0, t);
        sync();
        rst_n = 0;
        #1;
        chk("t6_busy", 32'(bus.busy), 0);
        chk("t6_valid", 32'(bus.rsp_valid), 0);
        chk("t6_data", 32'(bus.rsp_data), 0);
        chk("t6_id", 32'(bus.rsp_id), 0);
        repeat (2) @(negedge clk);
        sync();
        rst_n = 1;
        gq.delete();
        fork
            issue(0, 4'b0011, 3'd1, 0, t);
            issue(1, 4'b0011, 3'd1, 1, t2);
        join
        wait_idle();
        chk("t6_first_grant", (gq.size() > 0) ? 32'(gq[0]) : 32'hFFFF, 0);
        repeat (3) @(negedge clk);
        chk("total_rsp", 32'(n_rsp), 17);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end
endmodule
